multicycle_control: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Sequences the datapath through fetch, decode, execute, memory and writeback.

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/mc_output_decode.sv | 73 +++++++
 rtl/multicycle_control.sv | 95 +++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encoding,
// opcodes, OpALU codes (also consumed by the ALU control decoder) and mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SEXT2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word produced for one cycle
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] op_alu;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave).
// state is a debug view of the FSM state register.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] OpALU;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource, instr_done,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, OpALU, PCSource, instr_done,
           illegal_op, state
  );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode: state (plus mem_ready in the memory states) -> control word.
module mc_output_decode
  import mc_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  state_e   state,
  input  logic     mem_ready,
  output ctrl_t    ctrl
);

  logic rdy;
  assign rdy = mem_ready | ~WAIT_MEM;

  // Per-state strobes; everything not named in a state stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT2;
        ctrl.op_alu    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = rdy;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.op_alu    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.op_alu        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (R-type, lw, sw, beq, j).
// Opcode is captured in DECODE so MEMADR can pick lw/sw after IR may have moved on.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit         WAIT_MEM = 1'b1,
  parameter logic [5:0] OP_RTYPE = mc_pkg::OP_RTYPE,
  parameter logic [5:0] OP_LW    = mc_pkg::OP_LW,
  parameter logic [5:0] OP_SW    = mc_pkg::OP_SW,
  parameter logic [5:0] OP_BEQ   = mc_pkg::OP_BEQ,
  parameter logic [5:0] OP_J     = mc_pkg::OP_J
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  state_e     state_q, state_d;
  logic [5:0] opc_q, opc_d;
  logic       illegal_q, illegal_d;
  logic       rdy;
  ctrl_t      ctrl, ctrl_o;

  assign rdy = bus.mem_ready | ~WAIT_MEM;

  // State, latched opcode and the delayed illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        opc_d = bus.opcode;
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (bus.opcode == OP_J)                    state_d = S_JUMP;
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_output_decode #(.WAIT_MEM(WAIT_MEM)) u_dec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Reset kills every strobe immediately, even mid-instruction
  always_comb begin
    ctrl_o = ctrl;
    if (reset) ctrl_o = '0;
  end

  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.iord;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.OpALU       = ctrl_o.op_alu;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.instr_done  = ctrl_o.instr_done;
  assign bus.illegal_op  = illegal_q & ~reset;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: one row per clock cycle with
// inputs and the expected state / control outputs for that cycle.
module tb_multicycle_control;

  logic clk;
  logic reset;
  mc_ctrl_if bus ();

  multicycle_control #(.WAIT_MEM(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] w;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] w;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB[1:0],OpALU[1:0],PCSource[1:0],instr_done,illegal_op}
  function automatic logic [17:0] mk(
    input logic pcw, pcwc, iord, mr, mw, m2r, irw, rd, rw, asa,
    input logic [1:0] asb, op, pcs,
    input logic done, ill);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, rd, rw, asa, asb, op, pcs, done, ill};
  endfunction

  logic [17:0] W0, WF_RDY, WF_WAIT, WDEC, WMADR, WMRD, WMWB, WMWR_RDY, WMWR_WAIT,
               WEXEC, WALUWB, WBR, WJ, WILL;

  function automatic logic [17:0] observed();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.OpALU, bus.PCSource, bus.instr_done, bus.illegal_op};
  endfunction

  function automatic void add(input logic r, input logic [5:0] o, input logic m,
                              input logic [3:0] s, input logic [17:0] w);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.st = s; v.w = w;
    vecs.push_back(v);
  endfunction

  // Drive one row, push its expectation, then compare mid-cycle
  task automatic step(input vec_t v, input int id);
    exp_t e, got;
    reset         = v.rst;
    bus.opcode    = v.op;
    bus.mem_ready = v.rdy;
    e.st = v.st; e.w = v.w; e.id = id;
    sb.push_back(e);
    #4;
    got = sb.pop_front();
    checks++;
    if (bus.state !== got.st) begin
      errors++;
      $display("FAIL state row %0d: got %0d expected %0d", got.id, bus.state, got.st);
    end
    checks++;
    if (observed() !== got.w) begin
      errors++;
      $display("FAIL ctrl row %0d (state %0d): got %b expected %b", got.id, bus.state,
               observed(), got.w);
    end
    if (bus.instr_done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    W0        = '0;
    WF_WAIT   = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    WF_RDY    = mk(1,0,0,1,0,0,1,0,0,0,2'b01,2'b00,2'b00,0,0);
    WDEC      = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    WMADR     = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    WMRD      = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    WMWB      = mk(0,0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,1,0);
    WMWR_RDY  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    WMWR_WAIT = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    WEXEC     = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    WALUWB    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    WBR       = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    WJ        = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    WILL      = WF_RDY | 18'd1;

    // reset held two cycles, then release
    add(1, 6'h00, 1, 0, W0);
    add(1, 6'h00, 1, 0, W0);
    add(0, 6'h00, 0, 0, WF_WAIT);
    // lw, ready throughout; opcode changes after DECODE to prove it was latched
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b100011, 1, 1, WDEC);
    add(0, 6'b000000, 1, 2, WMADR);
    add(0, 6'h00, 1, 3, WMRD);
    add(0, 6'h00, 1, 4, WMWB);
    // sw with three wait cycles in MEMWR
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b101011, 0, 1, WDEC);
    add(0, 6'b100011, 0, 2, WMADR);
    add(0, 6'h00, 0, 5, WMWR_WAIT);
    add(0, 6'h00, 0, 5, WMWR_WAIT);
    add(0, 6'h00, 0, 5, WMWR_WAIT);
    add(0, 6'h00, 1, 5, WMWR_RDY);
    // R-type then beq then j (mem_ready toggled where it must be ignored)
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b000000, 0, 1, WDEC);
    add(0, 6'h00, 0, 6, WEXEC);
    add(0, 6'h00, 0, 7, WALUWB);
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b000100, 1, 1, WDEC);
    add(0, 6'h00, 0, 8, WBR);
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b000010, 1, 1, WDEC);
    add(0, 6'h00, 1, 9, WJ);
    // illegal opcode: back to FETCH with a single illegal_op pulse
    add(0, 6'h00, 1, 0, WF_RDY);
    add(0, 6'b111111, 1, 1, WDEC);
    add(0, 6'h00, 0, 0, WF_WAIT | 18'd1);
    add(0, 6'h00, 1, 0, WF_RDY);
    // lw stalled in MEMRD, then reset mid-instruction
    add(0, 6'b100011, 1, 1, WDEC);
    add(0, 6'h00, 0, 2, WMADR);
    add(0, 6'h00, 0, 3, WMRD);
    add(0, 6'h00, 0, 3, WMRD);
    add(1, 6'h00, 1, 3, W0);
    add(1, 6'h00, 1, 0, W0);
    add(0, 6'h00, 1, 0, WF_RDY);

    reset = 1'b1;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // five instructions finished (lw, sw, R-type, beq, j)
    checks++;
    if (done_cnt != 5) begin
      errors++;
      $display("FAIL instr_done_count: got %0d expected 5", done_cnt);
    end

    // Hand sequence: reset lands on the illegal_op pulse cycle, pulse must be masked
    begin
      vec_t h;
      h.rst = 0; h.op = 6'b111111; h.rdy = 1; h.st = 1; h.w = WDEC;
      step(h, 100);
      h.rst = 1; h.op = 6'h00; h.rdy = 1; h.st = 0; h.w = W0;
      step(h, 101);
      h.rst = 0; h.op = 6'h00; h.rdy = 0; h.st = 0; h.w = WF_WAIT;
      step(h, 102);
      // Hand sequence: R-type completes with ready low everywhere after FETCH
      h.rst = 0; h.op = 6'h00; h.rdy = 1; h.st = 0; h.w = WF_RDY;
      step(h, 103);
      h.rst = 0; h.op = 6'b000000; h.rdy = 0; h.st = 1; h.w = WDEC;
      step(h, 104);
      h.rst = 0; h.op = 6'h00; h.rdy = 0; h.st = 6; h.w = WEXEC;
      step(h, 105);
      h.rst = 0; h.op = 6'h00; h.rdy = 0; h.st = 7; h.w = WALUWB;
      step(h, 106);
      h.rst = 0; h.op = 6'h00; h.rdy = 0; h.st = 0; h.w = WF_WAIT;
      step(h, 107);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
